// File: rtl/apu_issue_queue_pkg.sv
// Shared types and widths for the APU request/response issue path.
// Defines the command/response records and the issue FSM state encoding.
package apu_issue_queue_pkg;

    localparam int unsigned APU_NARGS    = 3;
    localparam int unsigned APU_WOP      = 6;
    localparam int unsigned APU_NDSFLAGS = 15;
    localparam int unsigned APU_NUSFLAGS = 5;

    typedef struct packed {
        logic [APU_NARGS-1:0][31:0] operands;
        logic [APU_WOP-1:0]         op;
        logic [APU_NDSFLAGS-1:0]    flags;
    } apu_cmd_t;

    typedef struct packed {
        logic [31:0]             result;
        logic [APU_NUSFLAGS-1:0] flags;
    } apu_rsp_t;

    typedef enum logic {
        IDLE,
        REQ
    } apu_issue_state_t;

endpackage

// File: rtl/apu_issue_queue_if.sv
// Command, accelerator and response channels of the APU issue queue.
// master = the issue queue itself; slave = issuing stage, accelerator and consumer.
interface apu_issue_queue_if;
    import apu_issue_queue_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [31:0]             cmd_operands [2:0];
    logic [APU_WOP-1:0]      cmd_op;
    logic [APU_NDSFLAGS-1:0] cmd_flags;

    logic                    apu_req;
    logic [31:0]             apu_operands [2:0];
    logic [APU_WOP-1:0]      apu_op;
    logic [APU_NDSFLAGS-1:0] apu_flags_o;
    logic                    apu_gnt;
    logic                    apu_rvalid;
    logic [31:0]             apu_result;
    logic [APU_NUSFLAGS-1:0] apu_flags_i;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_result;
    logic [APU_NUSFLAGS-1:0] rsp_flags;

    modport master (
        input  cmd_valid, cmd_operands, cmd_op, cmd_flags,
        input  apu_gnt, apu_rvalid, apu_result, apu_flags_i,
        input  rsp_ready,
        output cmd_ready,
        output apu_req, apu_operands, apu_op, apu_flags_o,
        output rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        output cmd_valid, cmd_operands, cmd_op, cmd_flags,
        output apu_gnt, apu_rvalid, apu_result, apu_flags_i,
        output rsp_ready,
        input  cmd_ready,
        input  apu_req, apu_operands, apu_op, apu_flags_o,
        input  rsp_valid, rsp_result, rsp_flags
    );

endinterface

// File: rtl/apu_issue_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero when empty.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apu_issue_queue.sv
// Core-side APU initiator: buffers commands, issues them under a credit limit
// and returns accelerator results in order through a response FIFO.
module apu_issue_queue
    import apu_issue_queue_pkg::*;
#(
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    apu_issue_queue_if.master   bus,
    output logic                busy,
    output logic                err_unexpected_rvalid
);

    localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned RCW = $clog2(MAX_OUTSTANDING + 1);

    apu_issue_state_t state, state_next;
    apu_cmd_t         cmd_in, cmd_head;
    apu_rsp_t         rsp_in, rsp_head;

    logic           cmd_full, cmd_empty;
    logic           rsp_full, rsp_empty;
    logic [CCW-1:0] cmd_count;
    logic [RCW-1:0] rsp_count;
    logic [RCW-1:0] outstanding;

    logic           cmd_push, grant, rsp_push, rsp_pop;
    int unsigned    cmd_next, used_next;

    assign cmd_in.operands = {bus.cmd_operands[2], bus.cmd_operands[1], bus.cmd_operands[0]};
    assign cmd_in.op       = bus.cmd_op;
    assign cmd_in.flags    = bus.cmd_flags;
    assign rsp_in          = {bus.apu_result, bus.apu_flags_i};

    assign cmd_push = bus.cmd_valid && !cmd_full;
    assign grant    = (state == REQ) && bus.apu_gnt;
    assign rsp_push = bus.apu_rvalid && (outstanding != '0);
    assign rsp_pop  = !rsp_empty && bus.rsp_ready;

    sync_fifo #(.WIDTH($bits(apu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (cmd_push),
        .pop     (grant),
        .din     (cmd_in),
        .head    (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    sync_fifo #(.WIDTH($bits(apu_rsp_t)), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (rsp_push),
        .pop     (rsp_pop),
        .din     (rsp_in),
        .head    (rsp_head),
        .full    (rsp_full),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            outstanding           <= '0;
            err_unexpected_rvalid <= 1'b0;
        end else begin
            if (grant && !rsp_push)      outstanding <= outstanding + 1'b1;
            else if (!grant && rsp_push) outstanding <= outstanding - 1'b1;
            if (bus.apu_rvalid && (outstanding == '0)) err_unexpected_rvalid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_next;
    end

    // Decisions use next-cycle occupancy: a response popped now frees its credit
    // for the request that starts next cycle; a return alone moves a credit
    // from outstanding to buffered and frees nothing.
    always_comb begin
        cmd_next   = 32'(cmd_count) + 32'(cmd_push) - 32'(grant);
        used_next  = 32'(outstanding) + 32'(rsp_count) + 32'(grant) - 32'(rsp_pop);
        state_next = state;
        unique case (state)
            IDLE: if (cmd_next != 0 && used_next < MAX_OUTSTANDING) state_next = REQ;
            REQ:  if (bus.apu_gnt)
                      state_next = (cmd_next != 0 && used_next < MAX_OUTSTANDING) ? REQ : IDLE;
        endcase
    end

    always_comb begin
        bus.apu_req         = (state == REQ);
        bus.apu_operands[0] = cmd_head.operands[0];
        bus.apu_operands[1] = cmd_head.operands[1];
        bus.apu_operands[2] = cmd_head.operands[2];
        bus.apu_op          = cmd_head.op;
        bus.apu_flags_o     = cmd_head.flags;
    end

    assign bus.cmd_ready  = !cmd_full;
    assign bus.rsp_valid  = !rsp_empty;
    assign bus.rsp_result = rsp_head.result;
    assign bus.rsp_flags  = rsp_head.flags;
    assign busy           = !cmd_empty || (outstanding != '0) || !rsp_empty;

    // The credit limit guarantees a buffered slot for every outstanding result.
    assert property (@(posedge clk) disable iff (!n_reset) !(rsp_push && rsp_full));

endmodule

// File: tb/tb_apu_issue_queue.sv
// Self-checking bench for apu_issue_queue: directed scenarios plus a random run
// scored against a queue-based model of the command, credit and response rules.
module tb_apu_issue_queue;

    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned MAX_OUT   = 2;

    typedef struct packed {
        logic [31:0] a2, a1, a0;
        logic [5:0]  op;
        logic [14:0] fl;
    } tcmd_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
    } trsp_t;

    typedef struct packed {
        int unsigned due;
        trsp_t       r;
    } tret_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic busy;
    logic err;
    int   checks = 0;
    int   errors = 0;

    apu_issue_queue_if bus();

    apu_issue_queue #(.CMD_DEPTH(CMD_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                   (clk),
        .n_reset               (n_reset),
        .bus                   (bus),
        .busy                  (busy),
        .err_unexpected_rvalid (err)
    );

    always #5 clk = ~clk;

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.a0 = $urandom;
        c.a1 = $urandom;
        c.a2 = $urandom;
        c.op = 6'($urandom);
        c.fl = 15'($urandom);
        return c;
    endfunction

    function automatic trsp_t accel(input tcmd_t c);
        trsp_t r;
        r.res = (c.a0 + c.a1 + c.a2) ^ {26'd0, c.op};
        r.fl  = c.op[4:0] ^ c.fl[4:0];
        return r;
    endfunction

    function automatic tcmd_t head_cmd();
        tcmd_t c;
        c.a0 = bus.apu_operands[0];
        c.a1 = bus.apu_operands[1];
        c.a2 = bus.apu_operands[2];
        c.op = bus.apu_op;
        c.fl = bus.apu_flags_o;
        return c;
    endfunction

    task automatic drive_cmd(input tcmd_t c, input logic v);
        bus.cmd_valid       = v;
        bus.cmd_operands[0] = c.a0;
        bus.cmd_operands[1] = c.a1;
        bus.cmd_operands[2] = c.a2;
        bus.cmd_op          = c.op;
        bus.cmd_flags       = c.fl;
    endtask

    task automatic drive_ret(input logic v, input trsp_t r);
        bus.apu_rvalid  = v;
        bus.apu_result  = r.res;
        bus.apu_flags_i = r.fl;
    endtask

    task automatic idle_inputs();
        drive_cmd('0, 1'b0);
        drive_ret(1'b0, '0);
        bus.apu_gnt   = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.apu_req, bus.cmd_ready, bus.rsp_valid, busy, err} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_status got %b want 01000 (req,ready,rsp_valid,busy,err)",
                     {bus.apu_req, bus.cmd_ready, bus.rsp_valid, busy, err});
        end
        checks++;
        if ({head_cmd(), bus.rsp_result, bus.rsp_flags} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h / %h / %h want all zero",
                     head_cmd(), bus.rsp_result, bus.rsp_flags);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_single();
        tcmd_t c;
        trsp_t r;
        do_reset();
        c = '{a2: 32'h33, a1: 32'h22, a0: 32'h11, op: 6'h05, fl: 15'h0a5a};
        drive_cmd(c, 1'b1);
        @(negedge clk);
        drive_cmd(c, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.apu_req !== 1'b1 || head_cmd() !== c) begin
                errors++;
                $display("FAIL single_wait%0d got req=%b cmd=%h want req=1 cmd=%h",
                         i, bus.apu_req, head_cmd(), c);
            end
            @(negedge clk);
        end
        bus.apu_gnt = 1'b1;
        @(negedge clk);
        bus.apu_gnt = 1'b0;
        checks++;
        if ({bus.apu_req, busy} !== 2'b01) begin
            errors++;
            $display("FAIL single_after_gnt got req,busy=%b want 01", {bus.apu_req, busy});
        end
        r = '{res: 32'hDEADBEEF, fl: 5'h01};
        drive_ret(1'b1, r);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive_ret(1'b0, '0);
        checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_flags} !== r) begin
            errors++;
            $display("FAIL single_rsp got v=%b %h/%h want v=1 deadbeef/01",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_drain got rsp_valid,busy=%b want 00", {bus.rsp_valid, busy});
        end
    endtask

    task automatic test_burst();
        tcmd_t c [3];
        trsp_t r0;
        int    k = 0, grants = 0, first = -1, last = -1;
        logic  found = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            c[i] = rand_cmd();
            c[i].op = 6'(i + 1);
        end
        bus.apu_gnt = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.apu_req) begin
                checks++;
                if (grants < 3 && head_cmd() !== c[grants]) begin
                    errors++;
                    $display("FAIL burst_order%0d got %h want %h", grants, head_cmd(), c[grants]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                grants++;
            end
            if (k < 3) begin
                drive_cmd(c[k], 1'b1);
                if (bus.cmd_ready) k++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (grants != 2 || last - first != 1 || bus.apu_req !== 1'b0) begin
            errors++;
            $display("FAIL burst_grants got grants=%0d span=%0d req=%b want 2 grants span 1 req=0",
                     grants, last - first, bus.apu_req);
        end
        r0 = accel(c[0]);
        drive_ret(1'b1, r0);
        @(negedge clk);
        drive_ret(1'b0, '0);
        checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_flags} !== r0) begin
            errors++;
            $display("FAIL burst_rsp got v=%b %h/%h want v=1 %h/%h",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags, r0.res, r0.fl);
        end
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (bus.apu_req) found = 1'b1;
        end
        checks++;
        if (!found || head_cmd() !== c[2]) begin
            errors++;
            $display("FAIL burst_third got found=%b cmd=%h want found=1 cmd=%h", found, head_cmd(), c[2]);
        end
    endtask

    task automatic test_fill();
        tcmd_t c0, c;
        int    accepts = 0;
        do_reset();
        c0 = rand_cmd();
        for (int i = 0; i < 5; i++) begin
            c = (i == 0) ? c0 : rand_cmd();
            drive_cmd(c, 1'b1);
            if (bus.cmd_ready) accepts++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (accepts != 4 || bus.cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill got accepts=%0d ready=%b busy=%b want 4 0 1", accepts, bus.cmd_ready, busy);
        end
        checks++;
        if (bus.apu_req !== 1'b1 || head_cmd() !== c0) begin
            errors++;
            $display("FAIL fill_head got req=%b cmd=%h want req=1 cmd=%h", bus.apu_req, head_cmd(), c0);
        end
    endtask

    task automatic test_backpressure();
        tcmd_t       c [3];
        trsp_t       r0, r1;
        logic [31:0] got [$];
        int          k = 0;
        logic        issued = 1'b0;
        tcmd_t       issued_cmd = '0;
        do_reset();
        for (int i = 0; i < 3; i++) c[i] = rand_cmd();
        bus.rsp_ready = 1'b0;
        bus.apu_gnt   = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (k < 3) begin
                drive_cmd(c[k], 1'b1);
                if (bus.cmd_ready) k++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        r0 = accel(c[0]);
        r1 = accel(c[1]);
        drive_ret(1'b1, r0);
        @(negedge clk);
        drive_ret(1'b1, r1);
        @(negedge clk);
        drive_ret(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.apu_req !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_result !== r0.res) begin
                errors++;
                $display("FAIL bp_hold%0d got req=%b rsp_valid=%b res=%h want 0 1 %h",
                         i, bus.apu_req, bus.rsp_valid, bus.rsp_result, r0.res);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_valid) got.push_back(bus.rsp_result);
            if (bus.apu_req && !issued) begin
                issued     = 1'b1;
                issued_cmd = head_cmd();
            end
            @(negedge clk);
        end
        checks++;
        if (got.size() != 2 || got[0] !== r0.res || got[1] !== r1.res) begin
            errors++;
            $display("FAIL bp_order got n=%0d first=%h want n=2 %h then %h",
                     got.size(), (got.size() > 0) ? got[0] : 32'h0, r0.res, r1.res);
        end
        checks++;
        if (!issued || issued_cmd !== c[2]) begin
            errors++;
            $display("FAIL bp_resume got issued=%b cmd=%h want 1 %h", issued, issued_cmd, c[2]);
        end
    endtask

    task automatic test_unexpected_reset();
        do_reset();
        drive_ret(1'b1, '{res: 32'h12345678, fl: 5'h1f});
        @(negedge clk);
        drive_ret(1'b0, '0);
        checks++;
        if ({err, bus.rsp_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL unexp_rvalid got err,rsp_valid,busy=%b want 100", {err, bus.rsp_valid, busy});
        end
        drive_cmd(rand_cmd(), 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.apu_req !== 1'b1) begin
            errors++;
            $display("FAIL unexp_req got req=%b want 1", bus.apu_req);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({bus.apu_req, err, busy, bus.cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset got req,err,busy,ready=%b want 0001",
                     {bus.apu_req, err, busy, bus.cmd_ready});
        end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_random();
        tcmd_t       mq [$];
        trsp_t       rq [$];
        tret_t       pend [$];
        int unsigned m_out = 0, last_due = 0, due;
        logic        drained = 1'b0;
        logic        s_ready, s_req, s_rsp_valid, v, gnt, rdy, rv;
        tcmd_t       c, g;
        trsp_t       rr;
        do_reset();
        for (int unsigned cyc = 0; cyc < 800 && !drained; cyc++) begin
            logic drain;
            drain = (cyc >= 500);
            if (drain && mq.size() == 0 && pend.size() == 0 && rq.size() == 0 && busy === 1'b0) begin
                drained = 1'b1;
                break;
            end
            s_ready     = bus.cmd_ready;
            s_req       = bus.apu_req;
            s_rsp_valid = bus.rsp_valid;
            checks++;
            if (s_ready !== (mq.size() < CMD_DEPTH)) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, s_ready, mq.size() < CMD_DEPTH);
            end
            checks++;
            if (busy !== (mq.size() != 0 || m_out != 0 || rq.size() != 0)) begin
                errors++;
                $display("FAIL rnd_busy cyc %0d got %b queued=%0d out=%0d rsp=%0d",
                         cyc, busy, mq.size(), m_out, rq.size());
            end
            checks++;
            if (rq.size() > 0) begin
                if (s_rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_flags} !== rq[0]) begin
                    errors++;
                    $display("FAIL rnd_rsp cyc %0d got v=%b %h/%h want v=1 %h/%h",
                             cyc, s_rsp_valid, bus.rsp_result, bus.rsp_flags, rq[0].res, rq[0].fl);
                end
            end else if (s_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd_rsp cyc %0d got v=%b want v=0", cyc, s_rsp_valid);
            end
            if (s_req === 1'b1) begin
                checks++;
                if (mq.size() == 0 || m_out + rq.size() >= MAX_OUT || head_cmd() !== mq[0]) begin
                    errors++;
                    $display("FAIL rnd_req cyc %0d got cmd=%h queued=%0d used=%0d want head of %0d entries, used<%0d",
                             cyc, head_cmd(), mq.size(), m_out + rq.size(), mq.size(), MAX_OUT);
                end
            end
            c   = rand_cmd();
            v   = !drain && ($urandom_range(0, 1) == 1);
            gnt = drain || ($urandom_range(0, 2) != 0);
            rdy = drain || ($urandom_range(0, 3) != 0);
            rv  = (pend.size() > 0 && pend[0].due <= cyc);
            rr  = rv ? pend[0].r : trsp_t'($urandom);
            drive_cmd(c, v);
            bus.apu_gnt   = gnt;
            bus.rsp_ready = rdy;
            drive_ret(rv, rr);
            if (v && s_ready) mq.push_back(c);
            if (s_rsp_valid && rdy && rq.size() > 0) void'(rq.pop_front());
            if (s_req && gnt && mq.size() > 0) begin
                g = mq.pop_front();
                m_out++;
                due = cyc + $urandom_range(1, 5);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{due: due, r: accel(g)});
            end
            if (rv) begin
                void'(pend.pop_front());
                m_out--;
                rq.push_back(rr);
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL rnd_drain got queued=%0d out=%0d rsp=%0d busy=%b want all empty",
                     mq.size(), m_out, rq.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_backpressure();
        test_unexpected_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
